// File: rtl/effects_core.sv
// effects_core: echo/flanger sequencer over a shared circular sample RAM.
// Build option FLANGER_EN adds the flanger sweep; without it mode 10 is bypass.
module effects_core #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        effects_sel,
    input  logic [31:0]       par_delay1,
    input  logic [31:0]       par_delay2,
    input  logic [31:0]       offset_lowlimit,
    input  logic [31:0]       offset_uplimit,
    input  logic [DATA_W-1:0] data_adc,
    input  logic              data_rdy,
    output logic              start_tx,
    output logic [DATA_W-1:0] realt,
    output logic [DATA_W-1:0] delay1,
    output logic [DATA_W-1:0] delay2,
    output logic [DATA_W-1:0] effects_out,
    output logic              busy
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD1, S_RD2, S_OUT} state_t;
    typedef enum logic [1:0] {M_BYP, M_ECHO, M_FLG} mode_t;

    state_t            state_q;
    mode_t             mode_q, mode_d;
    logic              rdy_q, rise, we;
    logic [DATA_W-1:0] sample_q, tap1_q, tap2, rd_q;
    logic [DATA_W-1:0] mix_out, mix_d1, mix_d2;
    logic [ADDR_W-1:0] wr_ptr_q, d1_q, d2_q, d1_d, d2_d;
    logic [ADDR_W-1:0] addr_b, off_cur;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              unused_par;

    assign unused_par = ^{par_delay1[31:ADDR_W], par_delay2[31:ADDR_W]};
    assign rise = data_rdy & ~rdy_q;
    assign busy = (state_q != S_IDLE);

    always_comb begin
        mode_d = M_BYP;
        if (effects_sel[0]) mode_d = M_ECHO;
`ifdef FLANGER_EN
        else if (effects_sel[1]) mode_d = M_FLG;
`endif
    end

    always_comb begin
        d1_d = '0;
        d2_d = '0;
        unique case (mode_d)
            M_ECHO: begin
                d1_d = par_delay1[ADDR_W-1:0];
                d2_d = par_delay2[ADDR_W-1:0];
            end
            M_FLG:   d1_d = off_cur;
            default: ;
        endcase
    end

    assign addr_b = wr_ptr_q - ((state_q == S_WR) ? d1_q : d2_q);
    assign we     = (state_q == S_WR) && (mode_q != M_BYP);

    // Plain NBA read gives read-first behaviour on a same-address collision
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= sample_q;
        rd_q <= mem[addr_b];
    end

    assign tap2 = (d2_q == '0) ? sample_q : rd_q;

    always_comb begin
        mix_out = sample_q;
        mix_d1  = '0;
        mix_d2  = '0;
        unique case (mode_q)
            M_ECHO: begin
                mix_out = (sample_q >> 1) + (tap1_q >> 2) + (tap2 >> 2);
                mix_d1  = tap1_q;
                mix_d2  = tap2;
            end
            M_FLG: begin
                mix_out = (sample_q >> 1) + (tap1_q >> 1);
                mix_d1  = tap1_q;
            end
            default: ;
        endcase
    end

`ifdef FLANGER_EN
    logic [ADDR_W-1:0] lo, hi, off_q, off_nx;
    logic              up_q, up_nx, enter;
    logic              unused_flg;

    assign unused_flg = ^{offset_lowlimit[31:ADDR_W], offset_uplimit[31:ADDR_W]};
    assign lo      = offset_lowlimit[ADDR_W-1:0];
    assign hi      = offset_uplimit[ADDR_W-1:0];
    assign enter   = (mode_q != M_FLG);
    assign off_cur = enter ? lo : off_q;

    // Triangle sweep between lo and hi, turning around on the limit itself
    always_comb begin
        off_nx = off_q;
        up_nx  = up_q;
        if (lo >= hi) begin
            off_nx = lo;
            up_nx  = 1'b1;
        end else if (up_q) begin
            if (off_q < hi) begin
                off_nx = off_q + ADDR_W'(1);
                up_nx  = (off_q + ADDR_W'(1) != hi);
            end else begin
                up_nx = 1'b0;
            end
        end else begin
            if (off_q > lo) begin
                off_nx = off_q - ADDR_W'(1);
                up_nx  = (off_q - ADDR_W'(1) == lo);
            end else begin
                up_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            off_q <= '0;
            up_q  <= 1'b1;
        end else if (state_q == S_IDLE && rise && mode_d == M_FLG && enter) begin
            off_q <= lo;
            up_q  <= 1'b1;
        end else if (state_q == S_OUT && mode_q == M_FLG) begin
            off_q <= off_nx;
            up_q  <= up_nx;
        end
    end
`else
    logic unused_flg;

    assign unused_flg = ^{offset_lowlimit, offset_uplimit, effects_sel[1]};
    assign off_cur    = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b0;
            mode_q      <= M_BYP;
            sample_q    <= '0;
            tap1_q      <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            wr_ptr_q    <= '0;
            start_tx    <= 1'b0;
            realt       <= '0;
            delay1      <= '0;
            delay2      <= '0;
            effects_out <= '0;
        end else begin
            rdy_q    <= data_rdy;
            start_tx <= 1'b0;
            unique case (state_q)
                S_IDLE: if (rise) begin
                    sample_q <= data_adc;
                    mode_q   <= mode_d;
                    d1_q     <= d1_d;
                    d2_q     <= d2_d;
                    state_q  <= S_WR;
                end
                S_WR:  state_q <= S_RD1;
                S_RD1: begin
                    tap1_q  <= (d1_q == '0) ? sample_q : rd_q;
                    state_q <= S_RD2;
                end
                S_RD2: begin
                    realt       <= sample_q;
                    delay1      <= mix_d1;
                    delay2      <= mix_d2;
                    effects_out <= mix_out;
                    start_tx    <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (mode_q != M_BYP) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_effects_core.sv
// tb_effects_core: directed stimulus against a sample-history model of the
// effects engine; every start_tx pulse is checked against the model queue.
module tb_effects_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  effects_sel;
    logic [31:0] par_delay1, par_delay2, offset_lowlimit, offset_uplimit;
    logic [7:0]  data_adc;
    logic        data_rdy;
    logic        start_tx, busy;
    logic [7:0]  realt, delay1, delay2, effects_out;

    effects_core dut (
        .clk(clk), .reset(reset), .effects_sel(effects_sel),
        .par_delay1(par_delay1), .par_delay2(par_delay2),
        .offset_lowlimit(offset_lowlimit), .offset_uplimit(offset_uplimit),
        .data_adc(data_adc), .data_rdy(data_rdy), .start_tx(start_tx),
        .realt(realt), .delay1(delay1), .delay2(delay2),
        .effects_out(effects_out), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef FLANGER_EN
    localparam bit FLG = 1'b1;
`else
    localparam bit FLG = 1'b0;
`endif

    typedef struct {
        int         cyc;
        bit         known;
        logic [7:0] rt, out, d1, d2;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         nvec = 0, nerr = 0, npulse = 0;
    logic [7:0] last_out, last_d1, last_d2, last_rt;

    logic [7:0] mem_m [8192];
    bit         val_m [8192];
    int         ptr_m = 0;
    bit         prev_flg = 0;
    int         frun = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int flg_off(input int lo, input int hi, input int n);
        int span, p;
        if (lo >= hi) return lo;
        span = hi - lo;
        p = n % (2 * span);
        return (p <= span) ? lo + p : hi - (p - span);
    endfunction

    function automatic bit known(input int d);
        return d == 0 || val_m[(ptr_m - d) & 8191];
    endfunction

    function automatic logic [7:0] tapv(input int d, input logic [7:0] s);
        return (d == 0) ? s : mem_m[(ptr_m - d) & 8191];
    endfunction

    task automatic push(input logic [1:0] sel, input logic [7:0] s);
        exp_t e;
        int m, d1, d2, v;
        m = sel[0] ? 1 : ((sel == 2'b10 && FLG) ? 2 : 0);
        e.cyc = cyc + 4;
        e.rt = s;
        e.known = 1;
        e.out = s;
        e.d1 = 0;
        e.d2 = 0;
        if (m == 1) begin
            d1 = par_delay1 & 8191;
            d2 = par_delay2 & 8191;
            e.known = known(d1) && known(d2);
            e.d1 = tapv(d1, s);
            e.d2 = tapv(d2, s);
            v = s / 2 + e.d1 / 4 + e.d2 / 4;
            e.out = v[7:0];
        end else if (m == 2) begin
            if (!prev_flg) frun = 0;
            d1 = flg_off(offset_lowlimit & 8191, offset_uplimit & 8191, frun);
            frun++;
            e.known = known(d1);
            e.d1 = tapv(d1, s);
            v = s / 2 + e.d1 / 2;
            e.out = v[7:0];
        end
        prev_flg = (m == 2);
        if (m != 0) begin
            mem_m[ptr_m] = s;
            val_m[ptr_m] = 1;
            ptr_m = (ptr_m + 1) & 8191;
        end
        q.push_back(e);
    endtask

    task automatic send(input logic [1:0] sel, input logic [7:0] s, input int hold);
        push(sel, s);
        data_adc = s;
        effects_sel = sel;
        data_rdy = 1'b1;
        repeat (hold) @(posedge clk);
        #1 data_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        ptr_m = 0;
        prev_flg = 0;
    endtask

    always @(negedge clk) begin
        if (reset && start_tx) begin
            npulse++;
            if (q.size() == 0) begin
                chk("unexpected_start_tx", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("start_tx_cycle", cyc, e.cyc);
                chk("realt", realt, e.rt);
                if (e.known) begin
                    chk("effects_out", effects_out, e.out);
                    chk("delay1", delay1, e.d1);
                    chk("delay2", delay2, e.d2);
                end
            end
            last_out = effects_out;
            last_d1 = delay1;
            last_d2 = delay2;
            last_rt = realt;
        end
    end

    initial begin
        int npre;
        reset = 1'b1;
        effects_sel = 2'b00;
        par_delay1 = 0;
        par_delay2 = 0;
        offset_lowlimit = 0;
        offset_uplimit = 0;
        data_adc = 8'h00;
        data_rdy = 1'b0;
        #2 reset = 1'b0;
        data_adc = 8'hC3;
        repeat (6) begin
            @(posedge clk);
            #1 data_rdy = ~data_rdy;
        end
        data_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_realt", realt, 0);
        chk("rst_delay1", delay1, 0);
        chk("rst_delay2", delay2, 0);
        chk("rst_effects_out", effects_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start_tx", start_tx, 0);
        chk("rst_pulses", npulse, 0);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        send(2'b00, 8'h5A, 1);
        chk("bypass_out", last_out, 8'h5A);
        chk("bypass_delay1", last_d1, 8'h00);

        par_delay1 = 3;
        par_delay2 = 5;
        for (int i = 1; i <= 8; i++) send(2'b01, 8'(i * 16), 1);
        chk("echo_tap1", last_d1, 8'h50);
        chk("echo_tap2", last_d2, 8'h30);
        chk("echo_out", last_out, 8'h60);

        send(2'b11, 8'h90, 1);
        chk("mode11_tap1", last_d1, 8'h60);
        chk("mode11_out", last_out, 8'h70);

        npre = npulse;
        send(2'b01, 8'h21, 20);
        chk("held_level_pulses", npulse - npre, 1);

        npre = npulse;
        push(2'b01, 8'h31);
        data_adc = 8'h31;
        effects_sel = 2'b01;
        data_rdy = 1'b1;
        @(posedge clk);
        #1 data_rdy = 1'b0;
        @(posedge clk);
        #1 data_adc = 8'h99;
        data_rdy = 1'b1;
        @(posedge clk);
        #1 data_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_edge_pulses", npulse - npre, 1);
        chk("busy_edge_realt", last_rt, 8'h31);

        npre = npulse;
        data_adc = 8'hEE;
        data_rdy = 1'b1;
        @(posedge clk);
        #1 data_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_in_rd1", busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_pulses", npulse - npre, 0);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        par_delay1 = 1;
        par_delay2 = 0;
        for (int i = 0; i <= 8192; i++) send(2'b01, 8'(i), 1);
        chk("wrap_tap1", last_d1, 8'hFF);
        chk("wrap_tap2_d0", last_d2, 8'h00);
        chk("wrap_out", last_out, 8'h3F);
        send(2'b01, 8'h77, 1);
        chk("wrap_ptr1_tap1", last_d1, 8'h00);
        chk("wrap_ptr1_out", last_out, 8'h58);
        par_delay1 = 0;
        send(2'b01, 8'h33, 1);
        chk("delay0_tap1", last_d1, 8'h33);
        chk("delay0_out", last_out, 8'h31);

        offset_lowlimit = 2;
        offset_uplimit = 4;
        for (int i = 0; i < 6; i++) send(2'b10, 8'(8'hA0 + i * 3), 1);
        send(2'b00, 8'h11, 1);
        offset_lowlimit = 6;
        offset_uplimit = 6;
        for (int i = 0; i < 4; i++) send(2'b10, 8'(8'hC0 + i * 5), 1);

        repeat (10) @(posedge clk);
        #1;
        chk("missing_start_tx", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/effects_core.md
Name: effects_core

Overview:
- Audio effects engine: echo and flanger processors sharing one on-chip dual-port sample RAM (8192 x 8, circular buffer).
- Each ADC sample announced by data_rdy is stored, delayed taps are read back, and a mixed 8-bit output is produced.
- A one-cycle start_tx pulse tells the downstream DAC/serializer that effects_out is valid.
- Sits behind the Wishbone register block, which supplies the mode and delay/limit settings.

Parameters:
ADDR_W, 13, RAM address width (depth 2**ADDR_W)
DATA_W, 8, sample width (unsigned offset-binary)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
effects_sel  in  2  bit0 echo enable, bit1 flanger enable
par_delay1  in  32  echo tap-1 delay in samples (bits [ADDR_W-1:0] used)
par_delay2  in  32  echo tap-2 delay in samples (bits [ADDR_W-1:0] used)
offset_lowlimit  in  32  flanger sweep minimum delay (low ADDR_W bits used)
offset_uplimit  in  32  flanger sweep maximum delay (low ADDR_W bits used)
data_adc  in  8  incoming sample
data_rdy  in  1  sample-valid strobe; the rising edge counts
start_tx  out  1  one-cycle pulse: effects_out/realt/delay1/delay2 updated
realt  out  8  current (undelayed) sample
delay1  out  8  tap-1 sample
delay2  out  8  tap-2 sample (echo only; 0 otherwise)
effects_out  out  8  mixed output
busy  out  1  sequencer not idle

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; wr_ptr=0; flanger offset=0, direction up.
  - State IDLE; data_rdy edge register cleared.
  - RAM contents not cleared.
- data_rdy is edge-detected: a level held high starts exactly one sequence. Edges arriving while busy=1 are ignored.
- Sequencer FSM: IDLE -> WR -> RD1 -> RD2 -> OUT -> IDLE. busy=1 in every state except IDLE.
  - IDLE: on rising edge of data_rdy, latch data_adc into the sample register, effects_sel into the mode register, and the active delays; go to WR.
  - WR: port A writes sample to RAM[wr_ptr] (suppressed when mode=00). Port B address = wr_ptr - d1.
  - RD1: capture port B data as tap1. Port B address = wr_ptr - d2.
  - RD2: capture tap2.
  - OUT: drive outputs, pulse start_tx for one cycle, wr_ptr += 1 (skipped when mode=00), update flanger offset; return to IDLE.
  - Latency: start_tx is high in the 4th cycle after the cycle that sampled the data_rdy rise. Minimum spacing between accepted samples is 5 cycles.
- RAM: 2**ADDR_W x DATA_W, synchronous read (1-cycle latency), read-first on same-address collision.
- Address arithmetic is modulo 2**ADDR_W; the pointer wraps 8191 -> 0 with no flag.
- A delay of 0 bypasses the RAM: the tap equals the current sample.
- Mode (latched per sample):
  - 00 bypass: effects_out = sample, delay1 = delay2 = 0.
  - 01 echo: d1 = par_delay1, d2 = par_delay2; effects_out = (sample>>1) + (tap1>>2) + (tap2>>2).
  - 10 flanger: d1 = current offset; delay2 = 0; effects_out = (sample>>1) + (tap1>>1).
  - 11: echo takes priority.
  - Sums never exceed 8 bits.
- Flanger offset:
  - On entering mode 10 (previous mode not 10) the offset loads offset_lowlimit, direction up.
  - Each OUT step: if up and offset < uplimit, offset+1; on reaching uplimit, direction flips to down. Symmetric behaviour going down to lowlimit.
  - If lowlimit >= uplimit, offset is held at lowlimit.
- A mode change mid-sequence takes effect on the next sample.
- Reset mid-sequence aborts the sequence; no start_tx pulse is produced.

Optional Feature:
- Macro FLANGER_EN.
- Defined: flanger sweep logic present; mode 10 behaves as specified.
- Undefined: flanger logic not compiled; offset ports ignored; mode 10 behaves as bypass (00). Mode 11 is still echo.

Test Plan:
- Reset: hold reset=0 with data_rdy pulses -> all outputs 0, busy=0, no start_tx; release -> wr_ptr=0.
- Bypass: mode 00, data_adc=0x5A, one data_rdy pulse -> start_tx 4 cycles later, effects_out=0x5A, delay1=0, wr_ptr unchanged.
- Echo: mode 01, par_delay1=3, par_delay2=5, feed samples 0x10,0x20,...,0x80 -> for 8th sample (0x80): tap1=0x50, tap2=0x30, effects_out=0x40+0x14+0x0C=0x60.
- Wrap: echo, par_delay1=1, write 8193 samples -> pointer wraps to 1; tap reads sample 8191 correctly; delay 0 returns current sample.
- Flanger: mode 10, lowlimit=2, uplimit=4 -> offsets per sample 2,3,4,3,2,3; lowlimit=6, uplimit=6 -> constant 6.
- Handshake: data_rdy held high 20 cycles -> exactly one start_tx; second edge during busy ignored; reset asserted in RD1 -> no pulse, FSM IDLE.
